jam_cost_arbiter: RTL
=====================

# jam_cost_arbiter

Shares the single cost-table read port (W/J address out, Cost data in) between NREQ requesters, e.g. the JAM permutation engine and a host/debug reader. Grants are round-robin with burst locking, so one requester can fetch a whole row without interleaving. Drives the W/J address registers and returns each Cost read to its requester through a fixed two-stage pipeline.

## Interface
- NREQ, 2: number of requesters (2..4).
- IDX_W, 3: width of W and J.
- COST_W, 7: width of Cost.
- MAX_BURST, 8: maximum beats per lock (1..8).
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset: one clock, synchronous, active-low (RST=0 resets on the next CLK edge).
- req  in  NREQ  per-requester beat request; holds with its address until granted.
- req_w  in  NREQ*IDX_W  worker index, slice i belongs to requester i.
- req_j  in  NREQ*IDX_W  job index, slice i.
- req_last  in  NREQ  marks the final beat of a burst.
- gnt  out  NREQ  beat accepted this cycle (combinational, one-hot or zero).
- W  out  IDX_W  registered cost-table worker address.
- J  out  IDX_W  registered cost-table job address.
- Cost  in  COST_W  cost-table data; combinational from W/J, valid in the same cycle.
- rvalid  out  NREQ  read data valid for requester i (one-hot or zero).
- rdata  out  COST_W  read data.
- busy  out  1  state is BURST, or a read is in flight.

## Operation
- State ARB:
  - Round-robin winner = first i with req[i], scanning from ptr upward and wrapping at NREQ.
  - gnt[winner]=1.
  - If the beat has req_last, or MAX_BURST==1: stay in ARB, ptr <= winner+1 (mod NREQ).
  - Otherwise: go to BURST, owner <= winner, beat_cnt <= 1.
  - No req: gnt=0, ptr unchanged.
- State BURST:
  - gnt[owner]=req[owner]; all other gnt bits are 0.
  - On an accepted beat: beat_cnt++.
  - Return to ARB with ptr <= owner+1 if req_last, or if beat_cnt reaches MAX_BURST on this beat (forced release; a missing req_last is not an error).
  - Owner drops req while locked: no grant that cycle, go to ARB, ptr <= owner+1. Others are arbitrated from the next cycle.
- Requests from non-owners are held and never dropped by the arbiter.
- Read pipeline, per accepted beat:
  - S1 registers W, J and tag=index, with v1=1.
  - S2 captures Cost into rdata and asserts rvalid[tag].
  - One beat per cycle; no back-pressure on the read return.
- busy = (state==BURST) | v1 | any rvalid.

## Timing
- Grant at edge t. W/J presented during cycle t+1. rdata/rvalid valid during cycle t+2. Latency is fixed at 2 cycles.
- Back-to-back beats reach full throughput: 1 beat/cycle.
- Reset values:
  - state=ARB, ptr=0, owner=0, beat_cnt=0.
  - W=0, J=0, v1=0.
  - rvalid=0, rdata=0, busy=0.
  - gnt=0 while RST=0.
- Reset mid-burst: lock and in-flight reads are discarded; no rvalid after reset. Requesters must reissue.
- beat_cnt width is clog2(MAX_BURST+1). Round-robin pointer arithmetic wraps modulo NREQ.

## Structure
- Shared package jam_pkg holds:
  - IDX_W and COST_W defaults.
  - arb_state_t enum {ARB, BURST}.
  - The NREQ limit constant.
- Sub-module jam_rr_pick: combinational round-robin picker. Inputs req, ptr; outputs one-hot pick and its index. Reused by future shared-resource blocks.
- Top holds the FSM, beat counter and two-stage read pipeline; roughly 180-250 lines total.

## Test plan
- Single-beat read: requester 0 reads W=3, J=5 with req_last, table value 42 -> gnt[0] at t, W=3/J=5 at t+1, rvalid[0]=1 with rdata=42 at t+2, busy low at t+3.
- Round-robin: both requesters issue continuous single-beat reads -> grants alternate 0,1,0,1 and each rvalid tag matches its grant two cycles later.
- Burst lock: requester 0 bursts 3 beats (last on the 3rd) while requester 1 requests throughout -> gnt[1]=0 for those 3 cycles, then gnt[1]=1 on the 4th cycle.
- Forced release: MAX_BURST=8, requester 0 holds req with no req_last, requester 1 waiting -> exactly 8 grants to requester 0, then requester 1 is granted.
- Owner drop: requester 0 deasserts req after beat 2 of a burst -> one cycle with gnt=0, then requester 1 is granted, ptr=1.
- Reset mid-burst: RST=0 for one edge during beat 2 of 4 -> next cycle W=J=0, rvalid=0, state ARB; a fresh request from requester 1 is granted immediately.

Source files
------------

// File: rtl/jam_pkg.sv
// Shared definitions for the JAM cost-table blocks: default widths, the
// requester limit and the arbiter state encoding.
package jam_pkg;

    localparam int JAM_IDX_W     = 3;
    localparam int JAM_COST_W    = 7;
    localparam int JAM_NREQ_MAX  = 4;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jam_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from ptr and wrapping at NREQ.
import jam_pkg::*;

module jam_rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [PTR_W-1:0] pick_idx,
    output logic             any
);

    logic [PTR_W-1:0] w_cand;

    // Walk the candidates from ptr, wrapping explicitly so no modulo is needed.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        w_cand   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[w_cand]) begin
                any          = 1'b1;
                pick[w_cand] = 1'b1;
                pick_idx     = w_cand;
            end else begin
                any = any;
            end
            if (w_cand == PTR_W'(NREQ - 1)) begin
                w_cand = '0;
            end else begin
                w_cand = w_cand + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin, burst-locking arbiter for the single cost-table read port,
// with a fixed two-stage read return (address register, then data register).
import jam_pkg::*;

module jam_cost_arbiter #(
    parameter int NREQ      = 2,
    parameter int IDX_W     = JAM_IDX_W,
    parameter int COST_W    = JAM_COST_W,
    parameter int MAX_BURST = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*IDX_W-1:0]   req_w,
    input  logic [NREQ*IDX_W-1:0]   req_j,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         gnt,
    output logic [IDX_W-1:0]        W,
    output logic [IDX_W-1:0]        J,
    input  logic [COST_W-1:0]       Cost,
    output logic [NREQ-1:0]         rvalid,
    output logic [COST_W-1:0]       rdata,
    output logic                    busy
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAXB_C = CNT_W'(MAX_BURST);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;

    logic [NREQ-1:0]    w_pick;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_any;
    logic [NREQ-1:0]    w_gnt;
    logic               w_accept;
    logic [PTR_W-1:0]   w_acc_idx;
    logic [IDX_W-1:0]   w_sel_w;
    logic [IDX_W-1:0]   w_sel_j;

    logic               r_v1;
    logic [PTR_W-1:0]   r_tag;
    logic [NREQ-1:0]    w_tag_oh;
    logic [IDX_W-1:0]   r_w;
    logic [IDX_W-1:0]   r_j;
    logic [NREQ-1:0]    r_rvalid;
    logic [COST_W-1:0]  r_rdata;

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
        if (idx == PTR_W'(NREQ - 1)) begin
            return '0;
        end else begin
            return idx + PTR_W'(1);
        end
    endfunction

    jam_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .any      (w_any)
    );

    assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus pointer/owner/beat bookkeeping for the accepted beat.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_beat_cnt;
        w_accept    = 1'b0;
        w_acc_idx   = r_owner;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_accept  = 1'b1;
                    w_acc_idx = w_pick_idx;
                    if (req_last[w_pick_idx] || (MAX_BURST == 1)) begin
                        w_ptr_nxt = rr_next(w_pick_idx);
                    end else begin
                        w_state_nxt = BURST;
                        w_owner_nxt = w_pick_idx;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end else begin
                    w_state_nxt = ARB;
                end
            end
            BURST: begin
                if (req[r_owner]) begin
                    w_accept  = 1'b1;
                    w_acc_idx = r_owner;
                    w_cnt_nxt = w_cnt_inc;
                    if (req_last[r_owner] || (w_cnt_inc == MAXB_C)) begin
                        w_state_nxt = ARB;
                        w_ptr_nxt   = rr_next(r_owner);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = BURST;
                    end
                end else begin
                    // Owner abandoned the lock: give the port back without a beat.
                    w_state_nxt = ARB;
                    w_ptr_nxt   = rr_next(r_owner);
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
            end
        endcase
    end

    // Grant outputs, forced low while reset is asserted.
    always_comb begin
        w_gnt = '0;
        if (RST) begin
            case (r_state)
                ARB:     w_gnt = w_pick;
                BURST:   w_gnt[r_owner] = req[r_owner];
                default: w_gnt = '0;
            endcase
        end else begin
            w_gnt = '0;
        end
    end

    // Arbitration bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ptr      <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Address slice of the accepted requester and one-hot of the in-flight tag.
    always_comb begin
        w_sel_w  = req_w[int'(w_acc_idx)*IDX_W +: IDX_W];
        w_sel_j  = req_j[int'(w_acc_idx)*IDX_W +: IDX_W];
        w_tag_oh = '0;
        w_tag_oh[r_tag] = 1'b1;
    end

    // Two-stage read return: S1 holds address and tag, S2 captures Cost.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_v1     <= 1'b0;
            r_tag    <= '0;
            r_w      <= '0;
            r_j      <= '0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_tag <= w_acc_idx;
                r_w   <= w_sel_w;
                r_j   <= w_sel_j;
            end else begin
                r_tag <= r_tag;
            end
            if (r_v1) begin
                r_rvalid <= w_tag_oh;
                r_rdata  <= Cost;
            end else begin
                r_rvalid <= '0;
            end
        end
    end

    assign gnt    = w_gnt;
    assign W      = r_w;
    assign J      = r_j;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign busy   = (r_state == BURST) | r_v1 | (|r_rvalid);

endmodule
